pipe_slice_reg: RTL and testbench

//  Parametrised pipeline register slice: valid/ready handshake, synchronous flush,

---
 rtl/pipe_slice_reg.sv | 151 +++++++++++++++
 tb/tb_pipe_slice_reg.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_slice_reg.sv
// Flow-controlled pipeline register slice: bypass, forward register or skid buffer.
// Ports: clk/rst (sync, active-high), flush, in_* upstream, out_* downstream, count.
module pipe_slice_reg #(
  parameter int unsigned           WIDTH     = 32,
  parameter logic [WIDTH-1:0]      RESET_VAL = '0,
  parameter int unsigned           MODE      = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       count
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_BUSY  = 2'd1,
    ST_FULL  = 2'd2
  } state_e;

  if (MODE == 0) begin : g_bypass

    logic unused_ctl;
    assign unused_ctl = ^{clk, rst, flush};

    assign out_valid = in_valid;
    assign out_data  = in_data;
    assign in_ready  = out_ready;
    assign count     = 2'd0;

  end else if (MODE == 1) begin : g_fwd

    logic             valid_q, valid_d;
    logic [WIDTH-1:0] main_q,  main_d;
    logic             in_fire, out_fire;

    // Ready may pass through combinationally from out_ready.
    assign in_ready  = !valid_q || out_ready;
    assign in_fire   = in_valid && in_ready;
    assign out_fire  = valid_q && out_ready;
    assign out_valid = valid_q;
    assign out_data  = main_q;
    assign count     = {1'b0, valid_q};

    always_comb begin
      valid_d = valid_q;
      main_d  = main_q;
      if (flush) begin
        // Beat accepted this cycle is dropped; data reg keeps value.
        valid_d = 1'b0;
      end else if (in_fire) begin
        valid_d = 1'b1;
        main_d  = in_data;
      end else if (out_fire) begin
        valid_d = 1'b0;
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        valid_q <= 1'b0;
        main_q  <= RESET_VAL;
      end else begin
        valid_q <= valid_d;
        main_q  <= main_d;
      end
    end

  end else begin : g_skid

    state_e           state_q, state_d;
    logic [WIDTH-1:0] main_q,  main_d;
    logic [WIDTH-1:0] skid_q,  skid_d;
    logic             ready_q, ready_d;
    logic             in_fire, out_fire;

    // in_ready comes straight from a flop to cut the backward path.
    assign in_ready  = ready_q;
    assign out_valid = (state_q != ST_EMPTY);
    assign out_data  = main_q;
    assign in_fire   = in_valid && ready_q;
    assign out_fire  = out_valid && out_ready;

    always_comb begin
      count = 2'd0;
      unique case (state_q)
        ST_BUSY: count = 2'd1;
        ST_FULL: count = 2'd2;
        default: count = 2'd0;
      endcase
    end

    always_comb begin
      state_d = state_q;
      main_d  = main_q;
      skid_d  = skid_q;
      if (flush) begin
        state_d = ST_EMPTY;
      end else begin
        unique case (state_q)
          ST_EMPTY: begin
            if (in_fire) begin
              state_d = ST_BUSY;
              main_d  = in_data;
            end
          end
          ST_BUSY: begin
            if (in_fire && !out_fire) begin
              state_d = ST_FULL;
              skid_d  = in_data;
            end else if (out_fire && !in_fire) begin
              state_d = ST_EMPTY;
            end else if (in_fire && out_fire) begin
              main_d  = in_data;
            end
          end
          ST_FULL: begin
            // Older beat sits in main, so skid moves up only on drain.
            if (out_fire) begin
              state_d = ST_BUSY;
              main_d  = skid_q;
            end
          end
          default: state_d = ST_EMPTY;
        endcase
      end
      ready_d = (state_d != ST_FULL);
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        state_q <= ST_EMPTY;
        main_q  <= RESET_VAL;
        skid_q  <= RESET_VAL;
        ready_q <= 1'b1;
      end else begin
        state_q <= state_d;
        main_q  <= main_d;
        skid_q  <= skid_d;
        ready_q <= ready_d;
      end
    end

  end

endmodule

// File: tb/tb_pipe_slice_reg.sv
// Directed and randomized checks of pipe_slice_reg in all three modes.
// Instances: u_m0 (bypass), u_m1 (forward, reset 0xDEAD), u_m2 (skid).
module tb_pipe_slice_reg;

  localparam int NBEATS = 10000;
  localparam int BUDGET = 70000;

  logic        clk = 1'b0;
  logic        rst;
  logic        fl  [3];
  logic        iv  [3];
  logic        ir  [3];
  logic [31:0] id  [3];
  logic        ov  [3];
  logic        orr [3];
  logic [31:0] od  [3];
  logic [1:0]  cnt [3];

  int errs   = 0;
  int checks = 0;

  always #5 clk = ~clk;

  pipe_slice_reg #(.WIDTH(32), .RESET_VAL(32'h0), .MODE(0)) u_m0 (
    .clk(clk), .rst(rst), .flush(fl[0]),
    .in_valid(iv[0]), .in_ready(ir[0]), .in_data(id[0]),
    .out_valid(ov[0]), .out_ready(orr[0]), .out_data(od[0]),
    .count(cnt[0])
  );

  pipe_slice_reg #(.WIDTH(32), .RESET_VAL(32'hDEAD), .MODE(1)) u_m1 (
    .clk(clk), .rst(rst), .flush(fl[1]),
    .in_valid(iv[1]), .in_ready(ir[1]), .in_data(id[1]),
    .out_valid(ov[1]), .out_ready(orr[1]), .out_data(od[1]),
    .count(cnt[1])
  );

  pipe_slice_reg #(.WIDTH(32), .RESET_VAL(32'h0), .MODE(2)) u_m2 (
    .clk(clk), .rst(rst), .flush(fl[2]),
    .in_valid(iv[2]), .in_ready(ir[2]), .in_data(id[2]),
    .out_valid(ov[2]), .out_ready(orr[2]), .out_data(od[2]),
    .count(cnt[2])
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard state for the random phase.
  int sent  [3];
  int rcvd  [3];
  logic        stall_p [3];
  logic [31:0] data_p  [3];
  int cyc;
  bit done;

  initial begin
    rst = 1'b1;
    for (int m = 0; m < 3; m++) begin
      fl[m] = 1'b0; iv[m] = 1'b0; orr[m] = 1'b0; id[m] = '0;
    end
    tick(); tick();
    rst = 1'b0;
    #1;

    // Reset state
    chk("m2_rst_valid", ov[2], 0);
    chk("m2_rst_count", cnt[2], 0);
    chk("m2_rst_data", od[2], 32'h0);
    chk("m2_rst_ready", ir[2], 1);
    chk("m1_rst_data", od[1], 32'hDEAD);
    chk("m1_rst_valid", ov[1], 0);
    chk("m1_rst_ready", ir[1], 1);

    // T1: back-to-back streaming, mode 2
    orr[2] = 1'b1; iv[2] = 1'b1; id[2] = 32'h11;
    tick();
    id[2] = 32'h22; #1;
    chk("t1_d11", od[2], 32'h11);
    chk("t1_v11", ov[2], 1);
    chk("t1_c11", cnt[2], 1);
    tick();
    id[2] = 32'h33; #1;
    chk("t1_d22", od[2], 32'h22);
    chk("t1_c22", cnt[2], 1);
    tick();
    iv[2] = 1'b0; #1;
    chk("t1_d33", od[2], 32'h33);
    chk("t1_c33", cnt[2], 1);
    tick();
    chk("t1_empty", ov[2], 0);
    chk("t1_cnt0", cnt[2], 0);

    // T2: fill skid with downstream stalled, then drain
    orr[2] = 1'b0; iv[2] = 1'b1; id[2] = 32'hA;
    tick();
    id[2] = 32'hB; #1;
    chk("t2_rdy_busy", ir[2], 1);
    chk("t2_cnt1", cnt[2], 1);
    tick();
    iv[2] = 1'b0; #1;
    chk("t2_cnt2", cnt[2], 2);
    chk("t2_rdy_full", ir[2], 0);
    chk("t2_dA", od[2], 32'hA);
    tick();
    chk("t2_hold_dA", od[2], 32'hA);
    chk("t2_hold_v", ov[2], 1);
    orr[2] = 1'b1; #1;
    chk("t2_rdy_still0", ir[2], 0);
    tick();
    chk("t2_dB", od[2], 32'hB);
    chk("t2_rdy_back", ir[2], 1);
    chk("t2_cnt_back", cnt[2], 1);
    tick();
    chk("t2_drained", ov[2], 0);

    // T3: flush while FULL, then flush a beat accepted in BUSY
    orr[2] = 1'b0; iv[2] = 1'b1; id[2] = 32'h5;
    tick();
    id[2] = 32'h6;
    tick();
    chk("t3_full", cnt[2], 2);
    id[2] = 32'h77; fl[2] = 1'b1;
    tick();
    fl[2] = 1'b0; iv[2] = 1'b0; #1;
    chk("t3_fl_valid", ov[2], 0);
    chk("t3_fl_cnt", cnt[2], 0);
    chk("t3_fl_rdy", ir[2], 1);
    orr[2] = 1'b1;
    tick();
    chk("t3_no_ghost", ov[2], 0);
    orr[2] = 1'b0; iv[2] = 1'b1; id[2] = 32'h88;
    tick();
    id[2] = 32'h99; fl[2] = 1'b1; #1;
    chk("t3_busy_rdy", ir[2], 1);
    tick();
    fl[2] = 1'b0; iv[2] = 1'b0; #1;
    chk("t3_drop_valid", ov[2], 0);
    chk("t3_drop_cnt", cnt[2], 0);

    // T4: mode 1 stall and same-cycle ready
    iv[1] = 1'b1; id[1] = 32'h1234; orr[1] = 1'b0; #1;
    chk("t4_rdy_empty", ir[1], 1);
    tick();
    id[1] = 32'h5678; #1;
    chk("t4_rdy_stall", ir[1], 0);
    chk("t4_d1234", od[1], 32'h1234);
    chk("t4_cnt1", cnt[1], 1);
    orr[1] = 1'b1; #1;
    chk("t4_rdy_comb", ir[1], 1);
    tick();
    iv[1] = 1'b0; #1;
    chk("t4_d5678", od[1], 32'h5678);
    chk("t4_v", ov[1], 1);
    tick();
    chk("t4_empty", ov[1], 0);
    chk("t4_cnt0", cnt[1], 0);
    orr[1] = 1'b0;

    // T6: mode 0 is pure wiring
    for (int k = 0; k < 4; k++) begin
      iv[0] = k[0]; orr[0] = k[1]; id[0] = 32'hC0DE0000 + k; #1;
      chk("t6_valid", ov[0], {31'b0, k[0]});
      chk("t6_ready", ir[0], {31'b0, k[1]});
      chk("t6_data", od[0], 32'hC0DE0000 + k);
      chk("t6_cnt", cnt[0], 0);
      tick();
    end

    // T5: random handshakes, all modes at once, scoreboarded
    rst = 1'b1;
    for (int m = 0; m < 3; m++) begin
      iv[m] = 1'b0; orr[m] = 1'b0;
      sent[m] = 0; rcvd[m] = 0; stall_p[m] = 1'b0; data_p[m] = '0;
    end
    tick();
    rst = 1'b0;
    cyc = 0;
    done = 1'b0;
    while (!done && cyc < BUDGET) begin
      for (int m = 0; m < 3; m++) begin
        iv[m]  = (sent[m] < NBEATS) ? 1'($urandom_range(0, 1)) : 1'b0;
        id[m]  = 32'(sent[m]);
        orr[m] = 1'($urandom_range(0, 1));
      end
      #1;
      for (int m = 0; m < 3; m++) begin
        chk("t5_count", 32'(cnt[m]), 32'(sent[m] - rcvd[m]));
        if (m != 0 && stall_p[m]) begin
          chk("t5_stable_v", ov[m], 1);
          chk("t5_stable_d", od[m], data_p[m]);
        end
        if (ov[m] && orr[m]) begin
          chk("t5_order", od[m], 32'(rcvd[m]));
          rcvd[m]++;
        end
        if (iv[m] && ir[m])
          sent[m]++;
        stall_p[m] = ov[m] && !orr[m];
        data_p[m]  = od[m];
      end
      done = (rcvd[0] == NBEATS) && (rcvd[1] == NBEATS) &&
             (rcvd[2] == NBEATS);
      tick();
      cyc++;
    end
    for (int m = 0; m < 3; m++)
      chk("t5_all_rcvd", 32'(rcvd[m]), 32'(NBEATS));

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
